stats_collector_avlstrm: RTL
============================

Name: stats_collector_avlstrm

Overview:
- Receive end of the stats channel; each stats_packer_avlstrm instance drives one of these.
- Accepts framed stats records {addr,val} on an Avalon-ST style input and accumulates them in a shadow array.
- Commits a complete frame to a live register file atomically, so a host CSR read never sees a half-updated snapshot.
- One collector per clock domain (Clk, Clk_back), placed next to the host CSR decode.

Parameters:
- NUM_REGS, 16: number of live 32-bit stats registers.
- ADDR_W, 8: width of stats_t.addr; records with addr >= NUM_REGS are invalid.
- VAL_W, 32: width of stats_t.val.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous reset, active-high.
- in_data  in  ADDR_W+VAL_W  stats_t record, {addr, val}.
- in_valid  in  1  record valid.
- in_sop  in  1  first record of frame.
- in_eop  in  1  last record of frame.
- in_ready  out  1  collector can accept.
- hold  in  1  host freeze request; defers commit.
- rd_en  in  1  host read strobe.
- rd_addr  in  $clog2(NUM_REGS)  host read index.
- rd_data  out  VAL_W  read result.
- rd_valid  out  1  rd_data valid.
- frame_cnt  out  32  committed frames.
- err_cnt  out  32  framing errors.
- badaddr_cnt  out  32  out-of-range records.

Behaviour:
- Reset: live, shadow and dirty bits = 0; FSM = IDLE; in_ready = 1; rd_data = 0; rd_valid = 0; all counters = 0. Reset mid-frame discards the frame with no commit.
- A beat is accepted when in_valid && in_ready. The record is one stats_t per beat.

FSM states: IDLE, IN_FRAME, COMMIT_WAIT.
- IDLE, beat with sop:
  - Write shadow[addr] and set dirty[addr].
  - If eop is also set, go to the commit step; otherwise go to IN_FRAME.
- IDLE, beat without sop:
  - Drop the record, err_cnt += 1, stay in IDLE.
- IN_FRAME, beat without sop:
  - Write shadow and set dirty.
  - On eop, go to the commit step.
- IN_FRAME, beat with sop:
  - err_cnt += 1 and clear all dirty bits; the partial frame is discarded.
  - This beat starts a new frame under the IDLE sop rules.
- Commit step:
  - If hold = 0: on the next edge, live[i] <= shadow[i] for every dirty i; dirty cleared; frame_cnt += 1; go to IDLE.
  - If hold = 1: go to COMMIT_WAIT.
- COMMIT_WAIT:
  - in_ready = 0.
  - When hold falls, commit on the next edge, then IDLE with in_ready = 1.
- in_ready = 1 in IDLE and IN_FRAME.

Record rules:
- Record with addr >= NUM_REGS: badaddr_cnt += 1, no shadow write. Its sop/eop still drive the FSM.
- Duplicate addr within a frame: the last value wins.
- Non-dirty live registers keep their old value on commit.

Read port:
- rd_en at cycle t gives rd_data = live[rd_addr] and rd_valid = 1 at t+1.
- rd_valid is a single-cycle pulse per rd_en; back-to-back reads give one result per cycle.
- Read in the same cycle as a commit returns the pre-commit value.
- rd_addr >= NUM_REGS returns 0 with rd_valid = 1.

Counters:
- All counters wrap modulo 2^32.
- If an err and a badaddr event occur on the same beat, both counters increment.

Decomposition:
- Shared package: stats_t (addr/val widths), REG_* address constants, STATS_ADDR_W, STATS_VAL_W, and the FSM enum stats_col_state_t.
- One sub-module: stats_regfile. It holds the shadow and live arrays plus the dirty vector, and has a write port, a commit strobe and a registered read port.
- The FSM and counters stay in the top module.

Test Plan:
- Frame {sop,a=0,v=5},{a=3,v=9},{eop,a=1,v=7}, hold = 0 -> one cycle after eop, reads give live[0]=5, live[1]=7, live[3]=9; frame_cnt = 1; other registers 0.
- Single beat with sop = eop = 1, a = 2, v = 0xDEADBEEF -> live[2] = 0xDEADBEEF, frame_cnt = 1. A read of addr 2 in the commit cycle returns 0, and the read the next cycle returns 0xDEADBEEF.
- hold = 1 before eop -> in_ready = 0 and live is unchanged while hold is high. Dropping hold commits on the next edge, then in_ready = 1 and frame_cnt increments.
- Frame sop a=0 v=1, then a new sop a=0 v=2 with eop -> err_cnt = 1, live[0] = 2, frame_cnt = 1. Separately, a beat without sop in IDLE -> err_cnt += 1, live unchanged.
- Record a = 20 with NUM_REGS = 16 inside a valid frame -> badaddr_cnt = 1, other records commit, frame_cnt = 1.
- Assert Rst mid-frame after 2 beats -> all outputs 0; the next full frame commits only its own records; frame_cnt = 1.

Source files
------------

// File: rtl/stats_collector_avlstrm_pkg.sv
// Shared types for the stats channel receive side: record layout, well-known
// stats addresses and the collector FSM encoding.
package stats_collector_avlstrm_pkg;

  localparam int STATS_ADDR_W = 8;
  localparam int STATS_VAL_W  = 32;

  localparam logic [STATS_ADDR_W-1:0] REG_RX_FRAMES = 8'h00;
  localparam logic [STATS_ADDR_W-1:0] REG_RX_ERRORS = 8'h01;
  localparam logic [STATS_ADDR_W-1:0] REG_RX_BYTES  = 8'h02;
  localparam logic [STATS_ADDR_W-1:0] REG_RX_DROPS  = 8'h03;

  typedef struct packed {
    logic [STATS_ADDR_W-1:0] addr;
    logic [STATS_VAL_W-1:0]  val;
  } stats_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_FRAME,
    ST_COMMIT_WAIT
  } stats_col_state_t;

endpackage

// File: rtl/stats_regfile.sv
// Shadow/live register pair with per-entry dirty tracking and a registered
// host read port. A commit copies every dirty shadow entry into live at once.
module stats_regfile #(
  parameter  int NUM_REGS = 16,
  parameter  int ADDR_W   = 8,
  parameter  int VAL_W    = 32,
  localparam int RD_W     = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [VAL_W-1:0]  i_wrData,
  input  logic              i_clearDirty,
  input  logic              i_commit,
  input  logic              i_rdEn,
  input  logic [RD_W-1:0]   i_rdAddr,
  output logic [VAL_W-1:0]  o_rdData,
  output logic              o_rdValid
);

  logic [VAL_W-1:0]    r_shadow [NUM_REGS];
  logic [VAL_W-1:0]    r_live   [NUM_REGS];
  logic [NUM_REGS-1:0] r_dirty;
  logic [NUM_REGS-1:0] w_wrHit;
  logic [NUM_REGS-1:0] w_dirtyNext;
  logic [VAL_W-1:0]    w_rdVal;
  logic [VAL_W-1:0]    r_rdData;
  logic                r_rdValid;

  // Dirty set as it stands after this cycle's write, so a write landing on the
  // commit edge (last beat of a frame) is folded into that same commit.
  always_comb begin
    w_wrHit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wrHit[i] = i_wrEn && (i_wrAddr == ADDR_W'(i));
    end
    w_dirtyNext = (i_clearDirty ? {NUM_REGS{1'b0}} : r_dirty) | w_wrHit;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
      r_dirty <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wrHit[i]) begin
          r_shadow[i] <= i_wrData;
        end
        if (i_commit && w_dirtyNext[i]) begin
          r_live[i] <= w_wrHit[i] ? i_wrData : r_shadow[i];
        end
      end
      r_dirty <= i_commit ? {NUM_REGS{1'b0}} : w_dirtyNext;
    end
  end

  // Unmatched indices fall through to zero.
  always_comb begin
    w_rdVal = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_rdAddr == RD_W'(i)) begin
        w_rdVal = r_live[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= i_rdEn;
      if (i_rdEn) begin
        r_rdData <= w_rdVal;
      end
    end
  end

  assign o_rdData  = r_rdData;
  assign o_rdValid = r_rdValid;

endmodule

// File: rtl/stats_collector_avlstrm.sv
// Receive end of the stats channel: gathers framed {addr,val} records and
// publishes each complete frame to the host-visible registers atomically.
module stats_collector_avlstrm
  import stats_collector_avlstrm_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int ADDR_W   = STATS_ADDR_W,
  parameter  int VAL_W    = STATS_VAL_W,
  localparam int RD_W     = $clog2(NUM_REGS)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [ADDR_W+VAL_W-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  output logic                    in_ready,
  input  logic                    hold,
  input  logic                    rd_en,
  input  logic [RD_W-1:0]         rd_addr,
  output logic [VAL_W-1:0]        rd_data,
  output logic                    rd_valid,
  output logic [31:0]             frame_cnt,
  output logic [31:0]             err_cnt,
  output logic [31:0]             badaddr_cnt
);

  stats_col_state_t  r_state;
  stats_col_state_t  w_nextState;
  logic [ADDR_W-1:0] w_addr;
  logic [VAL_W-1:0]  w_val;
  logic              w_addrOk;
  logic              w_beat;
  logic              w_wrEn;
  logic              w_clearDirty;
  logic              w_commit;
  logic              w_errEvt;
  logic [31:0]       r_frameCnt;
  logic [31:0]       r_errCnt;
  logic [31:0]       r_badAddrCnt;

  assign w_addr   = in_data[ADDR_W+VAL_W-1 -: ADDR_W];
  assign w_val    = in_data[VAL_W-1:0];
  assign w_addrOk = (w_addr < ADDR_W'(NUM_REGS));
  assign in_ready = (r_state != ST_COMMIT_WAIT);
  assign w_beat   = in_valid && in_ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A sop arriving mid-frame aborts the partial frame and restarts with itself.
  always_comb begin
    w_nextState  = r_state;
    w_wrEn       = 1'b0;
    w_clearDirty = 1'b0;
    w_commit     = 1'b0;
    w_errEvt     = 1'b0;
    case (r_state)
      ST_IDLE, ST_IN_FRAME: begin
        if (w_beat) begin
          if (in_sop || (r_state == ST_IN_FRAME)) begin
            w_wrEn       = w_addrOk;
            w_clearDirty = in_sop && (r_state == ST_IN_FRAME);
            w_errEvt     = w_clearDirty;
            if (!in_eop) begin
              w_nextState = ST_IN_FRAME;
            end else if (hold) begin
              w_nextState = ST_COMMIT_WAIT;
            end else begin
              w_commit    = 1'b1;
              w_nextState = ST_IDLE;
            end
          end else begin
            w_errEvt = 1'b1;
          end
        end
      end
      ST_COMMIT_WAIT: begin
        if (!hold) begin
          w_commit    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_frameCnt   <= '0;
      r_errCnt     <= '0;
      r_badAddrCnt <= '0;
    end else begin
      if (w_commit) begin
        r_frameCnt <= r_frameCnt + 32'd1;
      end
      if (w_errEvt) begin
        r_errCnt <= r_errCnt + 32'd1;
      end
      if (w_beat && !w_addrOk) begin
        r_badAddrCnt <= r_badAddrCnt + 32'd1;
      end
    end
  end

  assign frame_cnt   = r_frameCnt;
  assign err_cnt     = r_errCnt;
  assign badaddr_cnt = r_badAddrCnt;

  stats_regfile #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .VAL_W    (VAL_W)
  ) u_regfile (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_wrEn       (w_wrEn),
    .i_wrAddr     (w_addr),
    .i_wrData     (w_val),
    .i_clearDirty (w_clearDirty),
    .i_commit     (w_commit),
    .i_rdEn       (rd_en),
    .i_rdAddr     (rd_addr),
    .o_rdData     (rd_data),
    .o_rdValid    (rd_valid)
  );

endmodule
